// File: rtl/vga_rect_engine.sv
// ---------------------------------------------------------------------------
// vga_rect_engine
// Parametrised VGA raster engine: a programmable-timing sync generator plus an
// N-rectangle compositor that drives 3-3-2 RGB pins.
//
// Ports
//   CLK_50        system clock
//   RST           synchronous active-high reset
//   rect_en       per-rectangle enable            (bit i = rect i)
//   rect_x/y      left edge / top edge            (rect i at [10i+9:10i])
//   rect_w/h      width in pixels / height in lines
//   rect_color    RRRGGGBB colour                 (rect i at [8i+7:8i])
//   bg_color      colour of active pixels that no rectangle covers (live)
//   RED/GREEN/BLUE colour pins, h_sync/v_sync sync pins
//   CounterX/Y    coordinate shown on the pins this cycle
//   InDisplayArea high while CounterX/Y lie inside the active area
//   frame_tick    one-cycle pulse in the cycle the outputs first show (0,0)
//   frame_count   frames since reset, wrapping
// ---------------------------------------------------------------------------
module vga_rect_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CLK_DIV  = 2,
  parameter int NUM_RECT = 2
) (
  input  logic                   CLK_50,
  input  logic                   RST,
  input  logic [NUM_RECT-1:0]    rect_en,
  input  logic [NUM_RECT*10-1:0] rect_x,
  input  logic [NUM_RECT*10-1:0] rect_y,
  input  logic [NUM_RECT*10-1:0] rect_w,
  input  logic [NUM_RECT*10-1:0] rect_h,
  input  logic [NUM_RECT*8-1:0]  rect_color,
  input  logic [7:0]             bg_color,
  output logic [2:0]             RED,
  output logic [2:0]             GREEN,
  output logic [1:0]             BLUE,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic [9:0]             CounterX,
  output logic [9:0]             CounterY,
  output logic                   InDisplayArea,
  output logic                   frame_tick,
  output logic [15:0]            frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0]       r_div;
  logic [NUM_RECT-1:0]    r_sh_en;
  logic [NUM_RECT*10-1:0] r_sh_x, r_sh_y, r_sh_w, r_sh_h;
  logic [NUM_RECT*8-1:0]  r_sh_c;

  logic                   w_step, w_xwrap, w_ywrap, w_load, w_de;
  logic [9:0]             w_nx, w_ny;
  logic [NUM_RECT-1:0]    w_sh_en;
  logic [NUM_RECT*10-1:0] w_sh_x, w_sh_y, w_sh_w, w_sh_h;
  logic [NUM_RECT*8-1:0]  w_sh_c;
  logic [NUM_RECT-1:0]    w_hit;
  logic [7:0]             w_color;

  // Shadow copies as they will be after this edge; at the frame boundary the
  // freshly latched geometry must already colour the very first pixel (0,0).
  assign w_sh_en = w_load ? rect_en    : r_sh_en;
  assign w_sh_x  = w_load ? rect_x     : r_sh_x;
  assign w_sh_y  = w_load ? rect_y     : r_sh_y;
  assign w_sh_w  = w_load ? rect_w     : r_sh_w;
  assign w_sh_h  = w_load ? rect_h     : r_sh_h;
  assign w_sh_c  = w_load ? rect_color : r_sh_c;

  // Next raster position; colour and syncs are computed from it so that all
  // registered outputs describe the same pixel with zero relative skew.
  always_comb begin
    w_step  = (r_div == DIV_LAST);
    w_xwrap = (CounterX == H_LAST);
    w_ywrap = (CounterY == V_LAST);
    w_load  = w_step & w_xwrap & w_ywrap;
    w_nx    = CounterX;
    w_ny    = CounterY;
    if (w_step) begin
      if (w_xwrap) begin
        w_nx = 10'd0;
        if (w_ywrap) begin
          w_ny = 10'd0;
        end else begin
          w_ny = CounterY + 10'd1;
        end
      end else begin
        w_nx = CounterX + 10'd1;
      end
    end else begin
      w_nx = CounterX;
    end
    w_de = (w_nx < H_ACT) && (w_ny < V_ACT);
  end

  // Hit test in 11 bits so x+w and y+h cannot overflow; w=0 or h=0 never hits.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_RECT; i++) begin
      w_hit[i] = w_sh_en[i]
               & ({1'b0, w_nx} >= {1'b0, w_sh_x[10*i +: 10]})
               & ({1'b0, w_nx} <  ({1'b0, w_sh_x[10*i +: 10]} + {1'b0, w_sh_w[10*i +: 10]}))
               & ({1'b0, w_ny} >= {1'b0, w_sh_y[10*i +: 10]})
               & ({1'b0, w_ny} <  ({1'b0, w_sh_y[10*i +: 10]} + {1'b0, w_sh_h[10*i +: 10]}));
    end
  end

  // Colour select: scan from highest index down so the lowest hitting index wins.
  always_comb begin
    w_color = bg_color;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_color = w_sh_c[8*i +: 8];
      end else begin
        w_color = w_color;
      end
    end
    if (!w_de) begin
      w_color = 8'h00;
    end else begin
      w_color = w_color;
    end
  end

  // Pixel divider, counters, shadow registers and all registered outputs.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      r_div         <= '0;
      CounterX      <= 10'd0;
      CounterY      <= 10'd0;
      r_sh_en       <= '0;
      r_sh_x        <= '0;
      r_sh_y        <= '0;
      r_sh_w        <= '0;
      r_sh_h        <= '0;
      r_sh_c        <= '0;
      RED           <= 3'd0;
      GREEN         <= 3'd0;
      BLUE          <= 2'd0;
      h_sync        <= ~SYNC_ACT;
      v_sync        <= ~SYNC_ACT;
      InDisplayArea <= 1'b0;
      frame_tick    <= 1'b0;
      frame_count   <= 16'd0;
    end else begin
      r_div         <= w_step ? '0 : (r_div + DIV_W'(1));
      CounterX      <= w_nx;
      CounterY      <= w_ny;
      r_sh_en       <= w_sh_en;
      r_sh_x        <= w_sh_x;
      r_sh_y        <= w_sh_y;
      r_sh_w        <= w_sh_w;
      r_sh_h        <= w_sh_h;
      r_sh_c        <= w_sh_c;
      RED           <= w_color[7:5];
      GREEN         <= w_color[4:2];
      BLUE          <= w_color[1:0];
      h_sync        <= ((w_nx >= HS_START) && (w_nx < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      v_sync        <= ((w_ny >= VS_START) && (w_ny < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      InDisplayArea <= w_de;
      frame_tick    <= w_load;
      frame_count   <= w_load ? (frame_count + 16'd1) : frame_count;
    end
  end

endmodule
